// File: rtl/mii_pkg.sv
// Shared MII lane constants, error/state enums and the registered output bundle
// for the receive-side frame parser.
package mii_pkg;

  localparam logic [7:0] MII_IDLE     = 8'h07;
  localparam logic [7:0] MII_START    = 8'hFB;
  localparam logic [7:0] MII_TERM     = 8'hFD;
  localparam logic [7:0] MII_PREAMBLE = 8'h55;
  localparam logic [7:0] MII_SFD      = 8'hD5;

  // Numeric order is also the priority order: the lowest code wins.
  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_BAD_PRE   = 3'd1,
    ERR_TAIL      = 3'd2,
    ERR_RUNT      = 3'd3,
    ERR_BAD_CTRL  = 3'd4,
    ERR_TOO_LONG  = 3'd5,
    ERR_TOO_SHORT = 3'd6
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_DROP
  } state_e;

  // Everything the parser presents, held in one register bank.
  typedef struct packed {
    logic [47:0] dst_addr;
    logic [47:0] src_addr;
    logic [15:0] eth_type;
    logic        hdr_valid;
    logic [63:0] payload_data;
    logic [7:0]  payload_keep;
    logic        payload_valid;
    logic        payload_last;
    logic [15:0] payload_len;
    logic        frame_done;
    logic        frame_err;
    err_code_e   err_code;
    logic [15:0] good_count;
    logic [15:0] err_count;
  } rx_out_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + 4'(v[i]);
    return cnt;
  endfunction

  // Byte carried by lane n of a 64-bit word (lane 0 is first on the wire).
  function automatic logic [7:0] lane(input logic [63:0] w, input int n);
    return w[8*n +: 8];
  endfunction

endpackage

// File: rtl/mii_rx_parser_if.sv
// Bus bundle between the MII lane source (master) and the frame parser (slave).
interface mii_rx_parser_if;
  logic [63:0] i_rx_data;
  logic [7:0]  i_rx_ctrl;
  logic [47:0] o_dst_addr;
  logic [47:0] o_src_addr;
  logic [15:0] o_type;
  logic        o_hdr_valid;
  logic [63:0] o_payload_data;
  logic [7:0]  o_payload_keep;
  logic        o_payload_valid;
  logic        o_payload_last;
  logic [15:0] o_payload_len;
  logic        o_frame_done;
  logic        o_frame_err;
  logic [2:0]  o_err_code;
  logic [15:0] o_good_count;
  logic [15:0] o_err_count;

  modport master (
    output i_rx_data, i_rx_ctrl,
    input  o_dst_addr, o_src_addr, o_type, o_hdr_valid, o_payload_data,
           o_payload_keep, o_payload_valid, o_payload_last, o_payload_len,
           o_frame_done, o_frame_err, o_err_code, o_good_count, o_err_count
  );

  modport slave (
    input  i_rx_data, i_rx_ctrl,
    output o_dst_addr, o_src_addr, o_type, o_hdr_valid, o_payload_data,
           o_payload_keep, o_payload_valid, o_payload_last, o_payload_len,
           o_frame_done, o_frame_err, o_err_code, o_good_count, o_err_count
  );
endinterface

// File: rtl/mii_lane_decode.sv
// Combinational classification of one 64-bit MII word: control-character type
// per lane, first control lane, and the payload keep mask starting at start_lane.
module mii_lane_decode
  import mii_pkg::*;
#(
  parameter logic [7:0] IDLE_CODE = MII_IDLE,
  parameter logic [7:0] TERM_CODE = MII_TERM
) (
  input  logic [63:0] data,
  input  logic [7:0]  ctrl,
  input  logic [3:0]  start_lane,
  output logic [7:0]  is_term,
  output logic [7:0]  is_idle,
  output logic [7:0]  is_other,
  output logic [3:0]  first_ctrl,
  output logic [7:0]  keep,
  output logic [3:0]  keep_cnt
);

  // Classify lanes, find the lowest control lane (8 = none), mask payload lanes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    is_term    = '0;
    is_idle    = '0;
    is_other   = '0;
    first_ctrl = 4'd8;
    keep       = '0;
    for (int i = 0; i < 8; i++) begin
      is_term[i]  = ctrl[i] && (lane(data, i) == TERM_CODE);
      is_idle[i]  = ctrl[i] && (lane(data, i) == IDLE_CODE);
      is_other[i] = ctrl[i] && !is_term[i] && !is_idle[i];
    end
    for (int i = 7; i >= 0; i--) begin
      if (ctrl[i]) first_ctrl = 4'(i);
    end
    for (int i = 0; i < 8; i++) begin
      keep[i] = (4'(i) >= start_lane) && (4'(i) < first_ctrl);
    end
  end

  assign keep_cnt = popcount8(keep);

endmodule

// File: rtl/mii_rx_parser.sv
// MII receive frame parser: validates preamble/SFD, extracts the Ethernet
// header, streams payload lanes and reports per-frame status and counters.
module mii_rx_parser
  import mii_pkg::*;
#(
  parameter int         DATA_WIDTH       = 64,
  parameter int         CTRL_WIDTH       = 8,
  parameter logic [7:0] IDLE_CODE        = MII_IDLE,
  parameter logic [7:0] START_CODE       = MII_START,
  parameter logic [7:0] TERM_CODE        = MII_TERM,
  parameter int         PAYLOAD_MAX_SIZE = 64,
  parameter int         PAYLOAD_MIN_SIZE = 1
) (
  input logic             clk,
  input logic             i_rst,
  mii_rx_parser_if.slave  bus
);

  if (DATA_WIDTH != 64 || CTRL_WIDTH != 8) begin : g_width_check
    $error("mii_rx_parser supports only a 64-bit data / 8-bit control lane bus");
  end

  localparam logic [15:0] MAX_LEN = 16'(PAYLOAD_MAX_SIZE);
  localparam logic [15:0] MIN_LEN = 16'(PAYLOAD_MIN_SIZE);

  state_e      state_q, state_d;
  err_code_e   drop_code_q, drop_code_d;
  err_code_e   frame_code;
  logic [47:0] dst_stage_q, dst_stage_d;
  logic [15:0] src_hi_stage_q, src_hi_stage_d;
  rx_out_t     out_q, out_d;

  logic [63:0] d;
  logic [7:0]  is_term, is_idle, is_other, keep;
  logic [3:0]  first_ctrl, keep_cnt, start_lane;
  logic [2:0]  first_idx;
  logic        has_ctrl, has_term, all_idle, first_is_term, bad_ctrl, tail_bad;
  logic        is_start0, pre_ok;
  logic [15:0] len_next;

  assign d = bus.i_rx_data;

  // Header words carry no payload except lanes 6-7 of the second one.
  assign start_lane = (state_q == ST_HDR1)    ? 4'd6 :
                      (state_q == ST_PAYLOAD) ? 4'd0 : 4'd8;

  mii_lane_decode #(.IDLE_CODE(IDLE_CODE), .TERM_CODE(TERM_CODE)) u_decode (
    .data       (d),
    .ctrl       (bus.i_rx_ctrl),
    .start_lane (start_lane),
    .is_term    (is_term),
    .is_idle    (is_idle),
    .is_other   (is_other),
    .first_ctrl (first_ctrl),
    .keep       (keep),
    .keep_cnt   (keep_cnt)
  );

  assign first_idx     = first_ctrl[2:0];
  assign has_ctrl      = !first_ctrl[3];
  assign has_term      = |is_term;
  assign all_idle      = &is_idle;
  assign first_is_term = has_ctrl && is_term[first_idx];
  assign bad_ctrl      = has_ctrl && (is_other[first_idx] || is_idle[first_idx]);
  assign is_start0     = bus.i_rx_ctrl[0] && (d[7:0] == START_CODE);
  assign pre_ok        = (bus.i_rx_ctrl[7:1] == 7'd0) &&
                         (d[55:8] == {6{MII_PREAMBLE}}) && (d[63:56] == MII_SFD);
  assign len_next      = out_q.payload_len + {12'd0, keep_cnt};

  // Any lane after the first control lane that is not an idle character.
  always_comb begin
    tail_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) > first_ctrl) && !is_idle[i]) tail_bad = 1'b1;
    end
  end

  // Lowest-numbered error among those hitting the current in-frame word.
  always_comb begin
    frame_code = ERR_NONE;
    if (first_is_term && tail_bad)                 frame_code = ERR_TAIL;
    else if (has_term && state_q != ST_PAYLOAD)    frame_code = ERR_RUNT;
    else if (bad_ctrl)                             frame_code = ERR_BAD_CTRL;
    else if (len_next > MAX_LEN)                   frame_code = ERR_TOO_LONG;
    else if (has_term && len_next < MIN_LEN)       frame_code = ERR_TOO_SHORT;
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_d        = state_q;
    drop_code_d    = drop_code_q;
    dst_stage_d    = dst_stage_q;
    src_hi_stage_d = src_hi_stage_q;
    out_d               = out_q;
    out_d.hdr_valid     = 1'b0;
    out_d.payload_data  = d;
    out_d.payload_keep  = '0;
    out_d.payload_last  = 1'b0;
    out_d.frame_done    = 1'b0;
    out_d.frame_err     = 1'b0;
    out_d.err_code      = ERR_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (is_start0) begin
          out_d.payload_len = '0;
          if (pre_ok) begin
            state_d = ST_HDR0;
          end else begin
            state_d     = ST_DROP;
            drop_code_d = ERR_BAD_PRE;
          end
        end
      end

      ST_HDR0, ST_HDR1, ST_PAYLOAD: begin
        out_d.payload_keep = keep;
        out_d.payload_len  = len_next;
        if (state_q == ST_HDR0 && !has_ctrl) begin
          dst_stage_d    = {lane(d, 0), lane(d, 1), lane(d, 2), lane(d, 3), lane(d, 4), lane(d, 5)};
          src_hi_stage_d = {lane(d, 6), lane(d, 7)};
        end
        if (state_q == ST_HDR1 && first_ctrl >= 4'd6) begin
          out_d.dst_addr  = dst_stage_q;
          out_d.src_addr  = {src_hi_stage_q, lane(d, 0), lane(d, 1), lane(d, 2), lane(d, 3)};
          out_d.eth_type  = {lane(d, 4), lane(d, 5)};
          out_d.hdr_valid = 1'b1;
        end
        if (has_term) begin
          out_d.payload_last = 1'b1;
          out_d.frame_done   = 1'b1;
          out_d.frame_err    = (frame_code != ERR_NONE);
          out_d.err_code     = frame_code;
          state_d            = ST_IDLE;
        end else if (frame_code != ERR_NONE) begin
          state_d     = ST_DROP;
          drop_code_d = frame_code;
        end else if (state_q == ST_HDR0) begin
          state_d = ST_HDR1;
        end else if (state_q == ST_HDR1) begin
          state_d = ST_PAYLOAD;
        end
      end

      ST_DROP: begin
        if (has_term || all_idle || is_start0) begin
          out_d.frame_done = 1'b1;
          out_d.frame_err  = 1'b1;
          out_d.err_code   = drop_code_q;
          state_d          = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    out_d.payload_valid = |out_d.payload_keep;

    if (out_d.frame_done) begin
      if (out_d.frame_err) begin
        if (out_q.err_count != 16'hFFFF) out_d.err_count = out_q.err_count + 16'd1;
      end else begin
        if (out_q.good_count != 16'hFFFF) out_d.good_count = out_q.good_count + 16'd1;
      end
    end
  end

  // FSM state and header staging registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      state_q        <= ST_IDLE;
      drop_code_q    <= ERR_NONE;
      dst_stage_q    <= '0;
      src_hi_stage_q <= '0;
    end else begin
      state_q        <= state_d;
      drop_code_q    <= drop_code_d;
      dst_stage_q    <= dst_stage_d;
      src_hi_stage_q <= src_hi_stage_d;
    end
  end

  // Registered output bank; reset clears every output.
  always_ff @(posedge clk) begin
    if (i_rst) out_q <= '0;
    else       out_q <= out_d;
  end

  assign bus.o_dst_addr      = out_q.dst_addr;
  assign bus.o_src_addr      = out_q.src_addr;
  assign bus.o_type          = out_q.eth_type;
  assign bus.o_hdr_valid     = out_q.hdr_valid;
  assign bus.o_payload_data  = out_q.payload_data;
  assign bus.o_payload_keep  = out_q.payload_keep;
  assign bus.o_payload_valid = out_q.payload_valid;
  assign bus.o_payload_last  = out_q.payload_last;
  assign bus.o_payload_len   = out_q.payload_len;
  assign bus.o_frame_done    = out_q.frame_done;
  assign bus.o_frame_err     = out_q.frame_err;
  assign bus.o_err_code      = out_q.err_code;
  assign bus.o_good_count    = out_q.good_count;
  assign bus.o_err_count     = out_q.err_count;

endmodule

// File: tb/tb_mii_rx_parser.sv
// Directed bench for mii_rx_parser: good frame, bad preamble, runt, length
// limits, bad control, bad tail and mid-frame reset, all with hand-worked values.
module tb_mii_rx_parser;

  // Word literals: lane 7 is the leftmost byte, lane 0 the rightmost.
  localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
  localparam logic [63:0] W_START = 64'hD5555555555555FB;
  localparam logic [63:0] W_BADPR = 64'hD5555555545555FB;
  localparam logic [63:0] W_HDR0  = 64'h2211FFFFFFFFFFFF;
  localparam logic [63:0] W_HDR1  = 64'hADDE000866554433;
  localparam logic [63:0] W_END6  = 64'h070707FD3412EFBE;
  localparam logic [63:0] W_TERM0 = 64'h07070707070707FD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  mii_rx_parser_if bus ();

  mii_rx_parser dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one word, then sample the outputs it produced just after the edge.
  task automatic tick(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    bus.i_rx_data = d;
    bus.i_rx_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_header();
    tick(W_START, 8'h01);
    tick(W_HDR0, 8'h00);
    tick(W_HDR1, 8'h00);
  endtask

  // Header plus the 6-byte DE AD BE EF 12 34 payload, ending with the terminate word.
  task automatic send_good_frame();
    send_header();
    tick(W_END6, 8'hF0);
  endtask

  initial begin
    bus.i_rx_data = W_IDLE;
    bus.i_rx_ctrl = 8'hFF;
    tick(W_IDLE, 8'hFF);
    tick(W_IDLE, 8'hFF);
    check("rst_done", bus.o_frame_done, 0);
    check("rst_valid", bus.o_payload_valid, 0);
    check("rst_data", bus.o_payload_data, 0);
    check("rst_good", bus.o_good_count, 0);
    check("rst_errc", bus.o_err_count, 0);
    rst = 1'b0;
    tick(W_IDLE, 8'hFF);
    check("idle_done", bus.o_frame_done, 0);

    // Good frame.
    send_header();
    check("f1_hdr_valid", bus.o_hdr_valid, 1);
    check("f1_dst", bus.o_dst_addr, 48'hFFFFFFFFFFFF);
    check("f1_src", bus.o_src_addr, 48'h112233445566);
    check("f1_type", bus.o_type, 16'h0800);
    check("f1_keep0", bus.o_payload_keep, 8'hC0);
    check("f1_valid0", bus.o_payload_valid, 1);
    check("f1_data0", bus.o_payload_data, W_HDR1);
    tick(W_END6, 8'hF0);
    check("f1_keep1", bus.o_payload_keep, 8'h0F);
    check("f1_last", bus.o_payload_last, 1);
    check("f1_done", bus.o_frame_done, 1);
    check("f1_err", bus.o_frame_err, 0);
    check("f1_code", bus.o_err_code, 0);
    check("f1_len", bus.o_payload_len, 6);
    check("f1_good", bus.o_good_count, 1);
    tick(W_IDLE, 8'hFF);
    check("f1_done_pulse", bus.o_frame_done, 0);
    check("f1_hdr_hold", bus.o_src_addr, 48'h112233445566);

    // Bad preamble: lane 3 is 0x54.
    tick(W_BADPR, 8'h01);
    check("bp_valid", bus.o_payload_valid, 0);
    check("bp_no_done", bus.o_frame_done, 0);
    tick(W_IDLE, 8'hFF);
    check("bp_done", bus.o_frame_done, 1);
    check("bp_err", bus.o_frame_err, 1);
    check("bp_code", bus.o_err_code, 1);
    check("bp_valid2", bus.o_payload_valid, 0);
    check("bp_errc", bus.o_err_count, 1);

    // Runt: terminate in lane 2 of the second header word.
    tick(W_START, 8'h01);
    tick(W_HDR0, 8'h00);
    tick(64'h0707070707FD4433, 8'hFC);
    check("runt_done", bus.o_frame_done, 1);
    check("runt_code", bus.o_err_code, 3);
    check("runt_hdr", bus.o_hdr_valid, 0);
    check("runt_errc", bus.o_err_count, 2);

    // 65-byte payload (2 + 7*8 + 7) ends with err 5, then a back-to-back good frame.
    send_header();
    for (int i = 0; i < 7; i++) tick(64'h0123456789ABCDEF ^ 64'(i), 8'h00);
    check("long_mid_len", bus.o_payload_len, 58);
    check("long_mid_done", bus.o_frame_done, 0);
    tick(64'hFD11111111111111, 8'h80);
    check("long_done", bus.o_frame_done, 1);
    check("long_code", bus.o_err_code, 5);
    check("long_len", bus.o_payload_len, 65);
    check("long_errc", bus.o_err_count, 3);
    send_good_frame();
    check("b2b_code", bus.o_err_code, 0);
    check("b2b_len", bus.o_payload_len, 6);
    check("b2b_good", bus.o_good_count, 2);

    // Exactly 64 payload bytes is accepted.
    send_header();
    for (int i = 0; i < 7; i++) tick(64'h1111111111111111, 8'h00);
    tick(64'h07FD222222222222, 8'hC0);
    check("max_done", bus.o_frame_done, 1);
    check("max_err", bus.o_frame_err, 0);
    check("max_len", bus.o_payload_len, 64);
    check("max_good", bus.o_good_count, 3);

    // Ctrl 0xFE in lane 3 mid-payload drops the frame with err 4.
    send_header();
    tick(64'hAAAAAAAAFEAAAAAA, 8'h08);
    check("bc_keep", bus.o_payload_keep, 8'h07);
    check("bc_no_done", bus.o_frame_done, 0);
    tick(64'h3333333333333333, 8'h00);
    check("bc_drop_valid", bus.o_payload_valid, 0);
    tick(W_TERM0, 8'hFF);
    check("bc_done", bus.o_frame_done, 1);
    check("bc_code", bus.o_err_code, 4);
    check("bc_errc", bus.o_err_count, 4);

    // Terminate in lane 5 followed by data 0x55 lanes: err 2.
    send_header();
    tick(64'h5555FDAAAAAAAAAA, 8'h20);
    check("tail_done", bus.o_frame_done, 1);
    check("tail_code", bus.o_err_code, 2);
    check("tail_keep", bus.o_payload_keep, 8'h1F);
    check("tail_errc", bus.o_err_count, 5);

    // One-cycle reset in the middle of a payload.
    send_header();
    tick(64'h4444444444444444, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    bus.i_rx_data = 64'h5555555555555555;
    bus.i_rx_ctrl = 8'h00;
    @(posedge clk);
    #1;
    check("mr_done", bus.o_frame_done, 0);
    check("mr_valid", bus.o_payload_valid, 0);
    check("mr_data", bus.o_payload_data, 0);
    check("mr_dst", bus.o_dst_addr, 0);
    check("mr_len", bus.o_payload_len, 0);
    check("mr_good", bus.o_good_count, 0);
    check("mr_errc", bus.o_err_count, 0);
    rst = 1'b0;
    tick(64'h6666666666666666, 8'h00);
    check("mr_ignored", bus.o_frame_done, 0);
    tick(W_TERM0, 8'hFF);
    check("mr_no_stale_done", bus.o_frame_done, 0);
    send_good_frame();
    check("mr_after_done", bus.o_frame_done, 1);
    check("mr_after_code", bus.o_err_code, 0);
    check("mr_after_good", bus.o_good_count, 1);
    check("mr_after_errc", bus.o_err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mii_rx_parser.md
Name: mii_rx_parser

Overview:
- Receive-side counterpart of mac_generator. Consumes a 64-bit data / 8-bit control MII lane stream (idle 0x07, start 0xFB, terminate 0xFD) and recovers each frame.
- Checks preamble and SFD, then extracts destination address, source address and EtherType.
- Streams payload bytes with a byte-keep mask and flags framing errors per frame.
- Sits between the MII loopback/PHY side and the MAC receive logic. mii_checker stays a passive monitor; this block is the functional receiver.

Parameters:
- DATA_WIDTH, 64, lane bus width; fixed to 64, assert otherwise.
- CTRL_WIDTH, 8, one control bit per byte lane.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character.
- TERM_CODE, 8'hFD, terminate control character.
- PAYLOAD_MAX_SIZE, 64, maximum accepted payload bytes.
- PAYLOAD_MIN_SIZE, 1, minimum accepted payload bytes.

Ports:
- clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_rx_data, in, 64, lane n = bits [8n+7:8n]; lane 0 is first on the wire.
- i_rx_ctrl, in, 8, bit n=1 means lane n carries a control character.
- o_dst_addr, out, 48, destination MAC; first wire byte is bits [47:40].
- o_src_addr, out, 48, source MAC, same byte order.
- o_type, out, 16, EtherType; first wire byte is bits [15:8].
- o_hdr_valid, out, 1, one-cycle pulse when all 14 header bytes are captured.
- o_payload_data, out, 64, registered copy of the input word.
- o_payload_keep, out, 8, lanes of o_payload_data that are payload bytes.
- o_payload_valid, out, 1, o_payload_keep is nonzero this cycle.
- o_payload_last, out, 1, last payload beat of the frame.
- o_payload_len, out, 16, payload byte count; valid with o_frame_done.
- o_frame_done, out, 1, one-cycle pulse at end of every frame, good or bad.
- o_frame_err, out, 1, qualifies o_frame_done.
- o_err_code, out, 3, error cause; valid with o_frame_done.
- o_good_count, out, 16, good frames received, saturating.
- o_err_count, out, 16, errored frames received, saturating.

Behaviour:
- Reset: every output is 0 and state is IDLE. Reset mid-frame discards the frame; no o_frame_done is produced for it.
- Latency: every output is registered, one cycle after the input word.
- IDLE:
  - Stays in IDLE while all 8 lanes are control 0x07.
  - Start (lane0 = ctrl 0xFB) with lanes 1-6 = data 0x55 and lane 7 = data 0xD5 -> HDR0.
  - 0xFB with a bad preamble or SFD -> DROP, err_code 1.
  - 0xFB in any lane other than 0 -> ignored, stay IDLE.
- HDR0: dst = lanes 0-5, src[47:32] = lanes 6-7 -> HDR1.
- HDR1:
  - src[31:0] = lanes 0-3, type = lanes 4-5; o_hdr_valid pulses.
  - Lanes 6-7 are payload and count toward the length.
  - Next state is PAYLOAD.
- PAYLOAD:
  - Data lanes before the first control lane are payload.
  - Terminate (ctrl 0xFD) in lane k: lanes 0..k-1 are payload, and o_payload_last plus o_frame_done assert in the same cycle.
  - Lanes after the terminate must be ctrl 0x07; otherwise err_code 2.
  - Then return to IDLE.
- Terminate in HDR0, HDR1, or at lane 6/7 of the HDR1 word -> runt, err_code 3, frame_done, IDLE.
- Any control character other than 0xFD in HDR or PAYLOAD (e.g. 0xFE, 0x07, 0xFB) -> err_code 4. Goes to DROP, or completes immediately if that word also holds a terminate.
- Running length > PAYLOAD_MAX_SIZE -> err_code 5 and DROP.
- Final length < PAYLOAD_MIN_SIZE -> err_code 6 at frame_done.
- Precedence when several errors hit the same word: lowest err_code wins. 0 = good.
- DROP:
  - Payload valid is suppressed.
  - Waits for a terminate or an all-idle word, then asserts frame_done with err=1 and returns to IDLE.
  - A start seen in DROP also ends the dropped frame. The next frame is not parsed from that start.
- Counters:
  - o_payload_len is 16 bits and increments by popcount(keep) each beat.
  - Each frame_done increments exactly one of good/err count; both saturate at 0xFFFF.
- Header fields hold their last captured value until the next HDR1.

Decomposition:
- Package mii_pkg holds:
  - the IDLE/START/TERM/PREAMBLE(0x55)/SFD(0xD5) constants;
  - the err_code enum (NONE, BAD_PRE, TAIL, RUNT, BAD_CTRL, TOO_LONG, TOO_SHORT);
  - the state enum (IDLE, HDR0, HDR1, PAYLOAD, DROP).
- mac_generator and mii_checker share mii_pkg.
- Sub-module mii_lane_decode (combinational) produces from one word:
  - a per-lane is_term/is_idle/is_other_ctrl vector;
  - the first-control-lane index;
  - the payload keep mask and its popcount.

Test Plan:
- mac_generator drives dst FF:FF:FF:FF:FF:FF, src 11:22:33:44:55:66, type 0x0800, 6-byte payload DE AD BE EF 12 34 -> o_hdr_valid with those fields. Payload beats are keep=0xC0 (DE AD), then keep=0x0F (BE EF 12 34) with the terminate in lane 4. len=6, err=0, good_count=1.
- Start word with lane 3 = 0x54 -> frame_done err_code 1, no payload_valid, err_count=1.
- Terminate in lane 2 of the HDR1 word -> err_code 3 (runt).
- Payload of 65 bytes with MAX=64 -> err_code 5. The next back-to-back valid frame parses with err=0.
- Ctrl 0xFE in lane 3 mid-payload -> err_code 4. Terminate in lane 5 with lanes 6-7 = 0x55 data -> err_code 2.
- Assert i_rst for one cycle during PAYLOAD -> all outputs 0 next cycle, no frame_done, counters 0. The following frame is received good.
